// File: rtl/fp_mult_share_arb.sv
// fp_mult_share_arb
//   Shares one pipelined floating-point multiplier among NUM_REQ requesters.
//   Each cycle at most one valid requester is granted. Its operands and index
//   are registered into an issue stage. They then travel through a STAGES-deep
//   multiplier pipeline, with the requester index riding alongside. Each result
//   returns on a one-hot strobe to the requester that issued it. The latency is
//   fixed and there is no backpressure.
//
//   Configuration macro: FP_MULT_ARB_RR_EN
//     defined   -> round-robin arbitration with a rotating start pointer
//     undefined -> fixed priority, lowest index wins (no pointer register)
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous drop of all in-flight work (blocks grant this cycle)
//   req_valid  per-requester operand valid
//   req_a      packed operand A, requester i at [i*W +: W]
//   req_b      packed operand B, requester i at [i*W +: W]
//   req_ready  one-hot grant (combinational); transfer = valid & ready
//   rsp_valid  one-hot result strobe to the originating requester
//   rsp_id     index of the originating requester (held between results)
//   rsp_z      product, broadcast to all requesters (held between results)
//   inflight   number of issued products not yet returned
module fp_mult_share_arb #(
    parameter int NUM_REQ   = 4,
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int STAGES    = 5
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         flush,
    input  logic [NUM_REQ-1:0]                           req_valid,
    input  logic [NUM_REQ*(SIG_WIDTH+EXP_WIDTH+1)-1:0]   req_a,
    input  logic [NUM_REQ*(SIG_WIDTH+EXP_WIDTH+1)-1:0]   req_b,
    output logic [NUM_REQ-1:0]                           req_ready,
    output logic [NUM_REQ-1:0]                           rsp_valid,
    output logic [(($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
    output logic [SIG_WIDTH+EXP_WIDTH:0]                 rsp_z,
    output logic [$clog2(STAGES+2)-1:0]                  inflight
);

    localparam int ID_W  = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
    localparam int W     = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int CNT_W = $clog2(STAGES + 2);
    localparam logic [EXP_WIDTH-1:0] BIAS = {1'b0, {(EXP_WIDTH-1){1'b1}}};

    // Truncating multiply: no rounding, no NaN/Inf/denormal handling.
    // A zero magnitude on either side yields +0.
    function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*SIG_WIDTH+1:0] prod;
        logic [EXP_WIDTH-1:0]   e;
        logic [SIG_WIDTH-1:0]   m;
        if (a[W-2:0] == '0 || b[W-2:0] == '0) begin
            return '0;
        end
        prod = {{(SIG_WIDTH+1){1'b0}}, 1'b1, a[SIG_WIDTH-1:0]}
             * {{(SIG_WIDTH+1){1'b0}}, 1'b1, b[SIG_WIDTH-1:0]};
        e = a[W-2 -: EXP_WIDTH] + b[W-2 -: EXP_WIDTH] - BIAS;
        // A product in [2,4) needs a one-bit renormalising shift.
        if (prod[2*SIG_WIDTH+1]) begin
            m = prod[2*SIG_WIDTH -: SIG_WIDTH];
            e = e + EXP_WIDTH'(1);
        end else begin
            m = prod[2*SIG_WIDTH-1 -: SIG_WIDTH];
        end
        return {a[W-1] ^ b[W-1], e, m};
    endfunction

    logic            gnt_any;
    logic [ID_W-1:0] gnt_id;

`ifdef FP_MULT_ARB_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Search starts at the pointer and wraps NUM_REQ-1 -> 0.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
        if (flush) gnt_any = 1'b0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    // Descending scan so the lowest valid index is the last (winning) write.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(k);
            end
        end
        if (flush) gnt_any = 1'b0;
    end
`endif

    assign req_ready = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;

    logic [W-1:0] a_sel, b_sel;
    assign a_sel = req_a[int'(gnt_id)*W +: W];
    assign b_sel = req_b[int'(gnt_id)*W +: W];

    logic            iss_vld_q;
    logic [W-1:0]    iss_a_q, iss_b_q;
    logic [ID_W-1:0] iss_id_q;

    logic [STAGES:1] vld_q;
    logic [W-1:0]    z_q  [1:STAGES];
    logic [ID_W-1:0] id_q [1:STAGES];

    logic             rsp_any;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    assign rsp_any = vld_q[STAGES];

    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (gnt_any && !rsp_any) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!gnt_any && rsp_any) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_vld_q  <= 1'b0;
            iss_a_q    <= '0;
            iss_b_q    <= '0;
            iss_id_q   <= '0;
            vld_q      <= '0;
            inflight_q <= '0;
            for (int s = 1; s <= STAGES; s++) begin
                z_q[s]  <= '0;
                id_q[s] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;

            // issue stage: operands held when nothing is granted
            iss_vld_q <= gnt_any;
            if (gnt_any) begin
                iss_a_q  <= a_sel;
                iss_b_q  <= b_sel;
                iss_id_q <= gnt_id;
            end

            // multiplier stage 1: product computed from the issue registers
            vld_q[1] <= iss_vld_q & ~flush;
            if (iss_vld_q && !flush) begin
                z_q[1]  <= fp_mul(iss_a_q, iss_b_q);
                id_q[1] <= iss_id_q;
            end

            // retiming stages 2..STAGES: data only advances with a live valid,
            // so the last stage keeps showing the last delivered result
            for (int s = 2; s <= STAGES; s++) begin
                vld_q[s] <= vld_q[s-1] & ~flush;
                if (vld_q[s-1] && !flush) begin
                    z_q[s]  <= z_q[s-1];
                    id_q[s] <= id_q[s-1];
                end
            end
        end
    end

    assign rsp_valid = rsp_any ? (NUM_REQ'(1) << id_q[STAGES]) : '0;
    assign rsp_id    = id_q[STAGES];
    assign rsp_z     = z_q[STAGES];
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_fp_mult_share_arb.sv
// tb_fp_mult_share_arb
//   Directed bench for fp_mult_share_arb with default parameters (4 requesters,
//   single-precision operands, 5 multiplier stages). Expected responses are
//   scheduled into a per-cycle table by the stimulus. A monitor compares the
//   response strobe against that table every cycle.
module tb_fp_mult_share_arb;

    localparam int NUM_REQ = 4;
    localparam int W       = 32;
    localparam int STAGES  = 5;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 3;
    localparam int LAT     = STAGES + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]   req_ready, rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [W-1:0]         rsp_z;
    logic [CNT_W-1:0]     inflight;

    fp_mult_share_arb #(
        .NUM_REQ(NUM_REQ), .SIG_WIDTH(23), .EXP_WIDTH(8), .STAGES(STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_z(rsp_z), .inflight(inflight)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [NUM_REQ-1:0] ev  [0:511];
    logic [ID_W-1:0]    eid [0:511];
    logic [W-1:0]       ez  [0:511];

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a response for a grant made in the current cycle.
    task automatic sched(input int id, input logic [W-1:0] z);
        ev[cyc+LAT]  = NUM_REQ'(1) << id;
        eid[cyc+LAT] = ID_W'(id);
        ez[cyc+LAT]  = z;
    endtask

    task automatic drive(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]    = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Per-cycle response monitor
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #3;
            chk_val("rsp_valid", 64'(rsp_valid), 64'(ev[cyc]));
            if (ev[cyc] != '0) begin
                chk_val("rsp_id", 64'(rsp_id), 64'(eid[cyc]));
                chk_val("rsp_z", 64'(rsp_z), 64'(ez[cyc]));
            end
        end
    end

    // Operand pairs and hand-computed products per requester
    logic [W-1:0] ta [0:3];
    logic [W-1:0] tb [0:3];
    logic [W-1:0] tz [0:3];

    initial begin
        for (int i = 0; i < 512; i++) begin
            ev[i] = '0; eid[i] = '0; ez[i] = '0;
        end
        ta[0] = 32'h3F800000; tb[0] = 32'h40000000; tz[0] = 32'h40000000; //  1.0 * 2.0  = 2.0
        ta[1] = 32'h40000000; tb[1] = 32'h40400000; tz[1] = 32'h40C00000; //  2.0 * 3.0  = 6.0
        ta[2] = 32'h3FC00000; tb[2] = 32'h3FC00000; tz[2] = 32'h40100000; //  1.5 * 1.5  = 2.25
        ta[3] = 32'hBFC00000; tb[3] = 32'h40200000; tz[3] = 32'hC0700000; // -1.5 * 2.5  = -3.75

        rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) step();
        chk_val("reset_ready", 64'(req_ready), 64'h0);
        chk_val("reset_rsp_id", 64'(rsp_id), 64'h0);
        chk_val("reset_rsp_z", 64'(rsp_z), 64'h0);
        chk_val("reset_inflight", 64'(inflight), 64'h0);
        rst_n = 1'b1;
        step();

`ifdef FP_MULT_ARB_RR_EN
        // all four requesters valid: rotation 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) drive(i, ta[i], tb[i]);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk_val("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k == 6) chk_val("rr_inflight_peak", 64'(inflight), 64'd6);
            sched(k % 4, tz[k % 4]);
            step();
        end
        req_valid = '0;
`else
        // requesters 0 and 3 valid: 0 always wins until it drops
        drive(0, ta[0], tb[0]);
        drive(3, ta[3], tb[3]);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_val("prio_grant0", 64'(req_ready), 64'b0001);
            sched(0, tz[0]);
            step();
        end
        req_valid[0] = 1'b0;
        #1;
        chk_val("prio_grant3", 64'(req_ready), 64'b1000);
        sched(3, tz[3]);
        step();
        req_valid = '0;
`endif
        repeat (LAT + 2) step();

        // single request on requester 2
        drive(2, 32'h3F800000, 32'h40000000);
        #1;
        chk_val("single_grant", 64'(req_ready), 64'b0100);
        sched(2, 32'h40000000);
        step();
        req_valid = '0;
        #1;
        chk_val("single_inflight", 64'(inflight), 64'd1);
        repeat (LAT) step();
        chk_val("hold_rsp_z", 64'(rsp_z), 64'h40000000);
        chk_val("hold_rsp_id", 64'(rsp_id), 64'd2);
        chk_val("idle_inflight", 64'(inflight), 64'd0);

        // zero operand on requester 1
        drive(1, 32'h00000000, 32'h40400000);
        #1;
        chk_val("zero_grant", 64'(req_ready), 64'b0010);
        sched(1, 32'h00000000);
        step();
        req_valid = '0;
        repeat (LAT + 1) step();

        // back-to-back products on requester 0, covering renormalise and sign
        for (int k = 1; k < 4; k++) begin
            drive(0, ta[k], tb[k]);
            #1;
            chk_val("b2b_grant", 64'(req_ready), 64'b0001);
            sched(0, tz[k]);
            step();
        end
        req_valid = '0;
        repeat (LAT + 1) step();

        // three issues, then flush: none of them may return
        for (int k = 0; k < 3; k++) begin
            req_valid = '0;
            drive(k, ta[k], tb[k]);
            step();
        end
        req_valid = '0;
        drive(3, ta[3], tb[3]);
        flush = 1'b1;
        #1;
        chk_val("flush_no_grant", 64'(req_ready), 64'h0);
        chk_val("flush_inflight_before", 64'(inflight), 64'd3);
        step();
        flush = 1'b0;
        #1;
        chk_val("flush_inflight_after", 64'(inflight), 64'd0);
        chk_val("post_flush_grant", 64'(req_ready), 64'b1000);
        sched(3, tz[3]);
        step();
        req_valid = '0;
        repeat (LAT + 1) step();

        // asynchronous reset mid-stream
        drive(0, ta[0], tb[0]);
        step();
        req_valid = '0;
        drive(1, ta[1], tb[1]);
        step();
        req_valid = '0;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk_val("areset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk_val("areset_rsp_id", 64'(rsp_id), 64'h0);
        chk_val("areset_rsp_z", 64'(rsp_z), 64'h0);
        chk_val("areset_inflight", 64'(inflight), 64'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (LAT) step();
        drive(2, 32'h40000000, 32'h40400000);
        #1;
        chk_val("post_reset_grant", 64'(req_ready), 64'b0100);
        sched(2, 32'h40C00000);
        step();
        req_valid = '0;
        repeat (LAT + 2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
